// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data requesters:
// grants one owner, registers its request, and steers the port handshakes back to it.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              sel_data
);

  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] STREAK_MAX = 2'd3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic [1:0]        streak, streak_nxt;
  logic              sel_nxt;
  logic              wr_nxt;
  logic [1:0]        size_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  // State and bus request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      sel_data  <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      sel_data  <= sel_nxt;
      bus_req   <= (state_nxt == ADDR);
      bus_wr    <= wr_nxt;
      bus_size  <= size_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
    end
  end

  // Grant selection and transaction sequencing
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    sel_nxt    = sel_data;
    wr_nxt     = bus_wr;
    size_nxt   = bus_size;
    addr_nxt   = bus_addr;
    wdata_nxt  = bus_wdata;
    case (state)
      IDLE: begin
        // Data wins unless fetch has already lost three grants in a row
        if (data_req && !(inst_req && (streak == STREAK_MAX))) begin
          state_nxt  = ADDR;
          sel_nxt    = 1'b1;
          wr_nxt     = data_wr;
          size_nxt   = data_size;
          addr_nxt   = data_addr;
          wdata_nxt  = data_wdata;
          streak_nxt = inst_req ? 2'(streak + 2'd1) : 2'd0;
        end else if (inst_req) begin
          state_nxt  = ADDR;
          sel_nxt    = 1'b0;
          wr_nxt     = 1'b0;
          size_nxt   = SIZE_WORD;
          addr_nxt   = inst_addr;
          wdata_nxt  = '0;
          streak_nxt = 2'd0;
        end
      end
      ADDR: begin
        if (bus_addr_ok) state_nxt = DATA;
      end
      DATA: begin
        if (bus_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshakes reach only the current owner and only in their own phase
  assign inst_addr_ok = (state == ADDR) && !sel_data && bus_addr_ok;
  assign data_addr_ok = (state == ADDR) &&  sel_data && bus_addr_ok;
  assign inst_data_ok = (state == DATA) && !sel_data && bus_data_ok;
  assign data_data_ok = (state == DATA) &&  sel_data && bus_data_ok;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: single fetch, contention, starvation guard,
// stalled port and reset in the middle of a transfer.
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              bus_req, bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok, bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  logic              sel_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .sel_data(sel_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the edge that moved the DUT into ADDR; leaves #1 after the edge back to IDLE.
  task automatic run_xact(input string tag, input logic exp_sel, input logic [31:0] exp_addr,
                          input logic exp_wr, input logic [1:0] exp_size,
                          input logic [31:0] exp_wdata, input logic [31:0] rdata,
                          input logic drop_req);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk({tag, ".bus_req"},  64'(bus_req), 64'(1));
    chk({tag, ".sel_data"}, 64'(sel_data), 64'(exp_sel));
    chk({tag, ".bus_addr"}, 64'(bus_addr), 64'(exp_addr));
    chk({tag, ".bus_wr"},   64'(bus_wr), 64'(exp_wr));
    chk({tag, ".bus_size"}, 64'(bus_size), 64'(exp_size));
    chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(exp_wdata));
    chk({tag, ".addr_ok"},  64'({inst_addr_ok, data_addr_ok}), 64'(exp_sel ? 2'b01 : 2'b10));
    step();
    bus_addr_ok = 1'b0;
    if (drop_req) begin
      if (exp_sel) data_req = 1'b0;
      else         inst_req = 1'b0;
    end
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    @(negedge clk);
    chk({tag, ".data_bus_req"}, 64'(bus_req), 64'(0));
    chk({tag, ".data_ok"}, 64'({inst_data_ok, data_data_ok}), 64'(exp_sel ? 2'b01 : 2'b10));
    chk({tag, ".rdata"}, 64'(exp_sel ? data_rdata : inst_rdata), 64'(rdata));
    step();
    bus_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // Reset state
    step();
    @(negedge clk);
    chk("rst.bus_req", 64'(bus_req), 64'(0));
    chk("rst.sel_data", 64'(sel_data), 64'(0));
    chk("rst.bus_regs", {bus_addr, bus_wdata}, 64'(0));
    chk("rst.wr_size", 64'({bus_wr, bus_size}), 64'(0));
    chk("rst.oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
    rst = 1'b0;

    // Single fetch
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    chk("fetch.idle_bus_req", 64'(bus_req), 64'(0));
    step();
    run_xact("fetch", 1'b0, 32'hBFC0_0000, 1'b0, 2'd2, 32'h0, 32'h2408_0001, 1'b1);
    @(negedge clk);
    chk("fetch.after_oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
    chk("fetch.after_bus_req", 64'(bus_req), 64'(0));

    // Simultaneous requests: data first, then inst
    step();
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    step();
    run_xact("simul.d", 1'b1, 32'h2000, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    @(negedge clk);
    chk("simul.idle_bus_req", 64'(bus_req), 64'(0));
    chk("simul.idle_sel_keep", 64'(sel_data), 64'(1));
    step();
    run_xact("simul.i", 1'b0, 32'h1000, 1'b0, 2'd2, 32'h0, 32'h1234_5678, 1'b1);

    // Starvation guard: D D D I repeating while both request continuously
    inst_req = 1'b1; inst_addr = 32'h3000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    data_addr = 32'h4000; data_wdata = 32'h1111_2222;
    for (int g = 0; g < 8; g++) begin
      step();
      if ((g % 4) == 3)
        run_xact($sformatf("starve.g%0d", g), 1'b0, 32'h3000, 1'b0, 2'd2, 32'h0, 32'(g), 1'b0);
      else
        run_xact($sformatf("starve.g%0d", g), 1'b1, 32'h4000, 1'b0, 2'd2, 32'h1111_2222, 32'(g), 1'b0);
    end
    inst_req = 1'b0; data_req = 1'b0;

    // Stalled port
    step();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1;
    data_addr = 32'h5000; data_wdata = 32'hA5A5_A5A5;
    step();
    for (int c = 0; c < 5; c++) begin
      bus_data_ok = (c == 2);
      @(negedge clk);
      chk($sformatf("stall.a%0d.bus_req", c), 64'(bus_req), 64'(1));
      chk($sformatf("stall.a%0d.oks", c),
          64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
      step();
    end
    bus_data_ok = 1'b0;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("stall.accept.bus_req", 64'(bus_req), 64'(1));
    chk("stall.accept.addr_ok", 64'(data_addr_ok), 64'(1));
    chk("stall.accept.size", 64'(bus_size), 64'(1));
    step();
    bus_addr_ok = 1'b0; data_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall.d%0d.bus_req", c), 64'(bus_req), 64'(0));
      chk($sformatf("stall.d%0d.oks", c),
          64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
      step();
    end
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("stall.done.data_ok", 64'(data_data_ok), 64'(1));
    chk("stall.done.rdata", 64'(data_rdata), 64'(32'hCAFE_F00D));
    step();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stall.post.oks", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));

    // Reset mid-DATA on a data transfer
    step();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h6000; data_wdata = 32'h5555_AAAA;
    step();
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("rstmid.in_data_sel", 64'(sel_data), 64'(1));
    rst = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    chk("rstmid.async_sel", 64'(sel_data), 64'(0));
    chk("rstmid.async_addr", 64'(bus_addr), 64'(0));
    chk("rstmid.async_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    bus_data_ok = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    bus_data_ok = 1'b1;
    @(negedge clk);
    chk("rstmid.late_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    chk("rstmid.bus_req", 64'(bus_req), 64'(0));
    chk("rstmid.sel", 64'(sel_data), 64'(0));
    step();
    bus_data_ok = 1'b0;

    // FSM back in IDLE: a new fetch is granted with normal latency
    inst_req = 1'b1; inst_addr = 32'h7000;
    @(negedge clk);
    chk("post.idle_bus_req", 64'(bus_req), 64'(0));
    step();
    run_xact("post", 1'b0, 32'h7000, 1'b0, 2'd2, 32'h0, 32'h0BAD_CAFE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
